// File: rtl/spram_frame_arbiter.sv
// spram_frame_arbiter: shares one SP256K (16K x 16) between camera capture writes
// and display scan-out reads. Reads win arbitration, but a read streak limit
// guarantees queued writes are eventually serviced.
// Optional feature: define SPRAM_STDBY_EN to drop the RAM into standby when idle.
module spram_frame_arbiter #(
   parameter int WR_FIFO_DEPTH = 4,
   parameter int MAX_RD_STREAK = 8,
   parameter int IDLE_CYCLES   = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [13:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic [3:0]  wr_mask,
   input  logic        rd_valid,
   output logic        rd_ready,
   input  logic [13:0] rd_addr,
   output logic [15:0] rd_data,
   output logic        rd_data_valid,
   output logic [13:0] spram_ad,
   output logic [15:0] spram_di,
   output logic [3:0]  spram_maskwe,
   output logic        spram_we,
   output logic        spram_cs,
   output logic        spram_stdby,
   output logic        spram_sleep,
   output logic        spram_pwroff_n,
   input  logic [15:0] spram_do
);

   localparam int AW = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = $clog2(MAX_RD_STREAK + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(WR_FIFO_DEPTH);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

   // Catch illegal configurations at elaboration rather than in silicon
   if (WR_FIFO_DEPTH < 2 || WR_FIFO_DEPTH > 16 ||
       (WR_FIFO_DEPTH & (WR_FIFO_DEPTH - 1)) != 0 ||
       MAX_RD_STREAK < 1 || IDLE_CYCLES < 1) begin : gBadParams
      $error("spram_frame_arbiter: illegal parameter value");
   end

   logic [13:0]   fifoAddr_q [WR_FIFO_DEPTH];
   logic [15:0]   fifoData_q [WR_FIFO_DEPTH];
   logic [3:0]    fifoMask_q [WR_FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] rdPtr_q;
   logic [CW-1:0] fifoCount_q;
   logic [SW-1:0] streak_q;

   logic          spramCs_q;
   logic          spramWe_q;
   logic [13:0]   spramAd_q;
   logic [15:0]   spramDi_q;
   logic [3:0]    spramMaskwe_q;
   logic [1:0]    rdPipe_q;
   logic [15:0]   rdData_q;
   logic          rdDataValid_q;

   logic          fifoEmpty;
   logic          push;
   logic          rdGrant;
   logic          wrGrant;
   logic          holdOff;

   assign fifoEmpty = (fifoCount_q == '0);
   assign wr_ready  = (fifoCount_q != FULL_COUNT);
   assign push      = wr_valid && wr_ready;
   assign rdGrant   = !holdOff && rd_valid && (fifoEmpty || (streak_q < STREAK_MAX));
   assign wrGrant   = !holdOff && !rdGrant && !fifoEmpty;
   assign rd_ready  = rdGrant;

`ifdef SPRAM_STDBY_EN
   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_LIMIT = IW'(IDLE_CYCLES);

   typedef enum logic [1:0] {PWR_ACTIVE, PWR_STANDBY, PWR_WAKE} pwrState_e;

   pwrState_e     pwrState_q;
   logic [IW-1:0] idleCount_q;
   logic          stdby_q;
   logic          busActive;

   assign busActive   = rd_valid || !fifoEmpty;
   assign holdOff     = (pwrState_q != PWR_ACTIVE);
   assign spram_stdby = stdby_q;

   // Idle counting, standby entry and the single no-grant wake cycle on exit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwrState_q  <= PWR_ACTIVE;
         idleCount_q <= '0;
         stdby_q     <= 1'b0;
      end else begin
         case (pwrState_q)
            PWR_ACTIVE: begin
               if (busActive) begin
                  idleCount_q <= '0;
               end else if (idleCount_q == IDLE_LIMIT) begin
                  pwrState_q <= PWR_STANDBY;
                  stdby_q    <= 1'b1;
               end else begin
                  idleCount_q <= idleCount_q + IW'(1);
               end
            end
            PWR_STANDBY: begin
               if (busActive) begin
                  pwrState_q  <= PWR_WAKE;
                  stdby_q     <= 1'b0;
                  idleCount_q <= '0;
               end
            end
            PWR_WAKE: begin
               pwrState_q <= PWR_ACTIVE;
            end
            default: begin
               pwrState_q <= PWR_ACTIVE;
               stdby_q    <= 1'b0;
            end
         endcase
      end
   end
`else
   assign holdOff     = 1'b0;
   assign spram_stdby = 1'b0;
`endif

   // FIFO payload storage; entries are only meaningful while covered by the count
   always_ff @(posedge clk) begin
      if (push) begin
         fifoAddr_q[wrPtr_q] <= wr_addr;
         fifoData_q[wrPtr_q] <= wr_data;
         fifoMask_q[wrPtr_q] <= wr_mask;
      end
   end

   // FIFO pointers and occupancy; a write grant is the pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + AW'(1);
         if (wrGrant) rdPtr_q <= rdPtr_q + AW'(1);
         case ({push, wrGrant})
            2'b10:   fifoCount_q <= fifoCount_q + CW'(1);
            2'b01:   fifoCount_q <= fifoCount_q - CW'(1);
            default: fifoCount_q <= fifoCount_q;
         endcase
      end
   end

   // Read streak: only counts reads that bypass a waiting write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         streak_q <= '0;
      end else if (fifoEmpty || wrGrant) begin
         streak_q <= '0;
      end else if (rdGrant && (streak_q < STREAK_MAX)) begin
         streak_q <= streak_q + SW'(1);
      end
   end

   // Registered SP256K control; address and data hold when the bus is idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spramCs_q     <= 1'b0;
         spramWe_q     <= 1'b0;
         spramAd_q     <= '0;
         spramDi_q     <= '0;
         spramMaskwe_q <= '0;
      end else begin
         spramCs_q <= rdGrant || wrGrant;
         spramWe_q <= wrGrant;
         if (rdGrant) begin
            spramAd_q <= rd_addr;
         end else if (wrGrant) begin
            spramAd_q     <= fifoAddr_q[rdPtr_q];
            spramDi_q     <= fifoData_q[rdPtr_q];
            spramMaskwe_q <= fifoMask_q[rdPtr_q];
         end
      end
   end

   // Read return: track each read through the RAM's one-cycle output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdPipe_q      <= '0;
         rdData_q      <= '0;
         rdDataValid_q <= 1'b0;
      end else begin
         rdPipe_q      <= {rdPipe_q[0], rdGrant};
         rdDataValid_q <= rdPipe_q[1];
         if (rdPipe_q[1]) rdData_q <= spram_do;
      end
   end

   assign spram_cs       = spramCs_q;
   assign spram_we       = spramWe_q;
   assign spram_ad       = spramAd_q;
   assign spram_di       = spramDi_q;
   assign spram_maskwe   = spramMaskwe_q;
   assign spram_sleep    = 1'b0;
   assign spram_pwroff_n = 1'b1;
   assign rd_data        = rdData_q;
   assign rd_data_valid  = rdDataValid_q;

endmodule
